// File: rtl/wb_core_bus_arbiter.sv
// Two-master Wishbone arbiter sharing the core bus between instruction (m0) and data (m1) masters.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_core_bus_arbiter #(
  parameter int PRIORITY_MODE  = 1,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  output logic [DATA_WIDTH-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  output logic [DATA_WIDTH-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    core_cyc_o,
  output logic                    core_stb_o,
  output logic                    core_we_o,
  output logic [DATA_WIDTH/8-1:0] core_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   core_addr_o,
  output logic [DATA_WIDTH-1:0]   core_data_o,
  input  logic [DATA_WIDTH-1:0]   core_data_i,
  input  logic                    core_ack_i,
  output logic [1:0]              grant_o
);

  typedef enum logic [1:0] {IDLE, OWN_M0, OWN_M1} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_core_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_t state, state_nxt;
  logic   last_winner, last_winner_nxt;  // 0 = m0, 1 = m1
  logic   req0, req1, timeout;

  function automatic state_t arb(input logic r0, input logic r1, input logic lw);
    if (r0 && r1) begin
      if (PRIORITY_MODE == 0) return OWN_M1;
      return lw ? OWN_M0 : OWN_M1;
    end
    if (r0) return OWN_M0;
    if (r1) return OWN_M1;
    return IDLE;
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  // Release re-arbitrates in the same cycle so a waiting master gets the bus without a dead cycle.
  always_comb begin
    state_nxt       = state;
    last_winner_nxt = last_winner;
    unique case (state)
      IDLE:    state_nxt = arb(req0, req1, last_winner);
      OWN_M0:  if (!m0_cyc_i) state_nxt = arb(req0, req1, last_winner);
               else if (timeout) state_nxt = IDLE;
      OWN_M1:  if (!m1_cyc_i) state_nxt = arb(req0, req1, last_winner);
               else if (timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == OWN_M0 && state != OWN_M0) last_winner_nxt = 1'b0;
    if (state_nxt == OWN_M1 && state != OWN_M1) last_winner_nxt = 1'b1;
  end

  always_comb begin
    core_cyc_o   = 1'b0;
    core_stb_o   = 1'b0;
    core_we_o    = 1'b0;
    core_wstrb_o = '0;
    core_addr_o  = '0;
    core_data_o  = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    m0_data_o    = core_data_i;
    m1_data_o    = core_data_i;
    unique case (state)
      OWN_M0: begin
        core_cyc_o   = m0_cyc_i;
        core_stb_o   = m0_stb_i;
        core_we_o    = m0_we_i;
        core_wstrb_o = m0_wstrb_i;
        core_addr_o  = m0_addr_i;
        core_data_o  = m0_data_i;
        m0_ack_o     = core_ack_i & m0_cyc_i;  // drop acks that land after release
      end
      OWN_M1: begin
        core_cyc_o   = m1_cyc_i;
        core_stb_o   = m1_stb_i;
        core_we_o    = m1_we_i;
        core_wstrb_o = m1_wstrb_i;
        core_addr_o  = m1_addr_i;
        core_data_o  = m1_data_i;
        m1_ack_o     = core_ack_i & m1_cyc_i;
      end
      default: ;
    endcase
  end

  assign grant_o = {state == OWN_M1, state == OWN_M0};

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        owner_cyc, stall, blk0, blk1;

  assign owner_cyc = (state == OWN_M0 && m0_cyc_i) || (state == OWN_M1 && m1_cyc_i);
  assign stall     = owner_cyc & core_stb_o & ~core_ack_i;
  assign timeout   = stall && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign m0_err_o  = timeout && (state == OWN_M0);
  assign m1_err_o  = timeout && (state == OWN_M1);
  // A timed-out master is locked out until it drops cyc.
  assign req0      = m0_cyc_i & ~blk0;
  assign req1      = m1_cyc_i & ~blk1;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      blk0   <= 1'b0;
      blk1   <= 1'b0;
    end else begin
      if (state_nxt != state || !owner_cyc || core_ack_i) to_cnt <= '0;
      else if (stall) to_cnt <= to_cnt + 16'd1;
      blk0 <= (blk0 | m0_err_o) & m0_cyc_i;
      blk1 <= (blk1 | m1_err_o) & m1_cyc_i;
    end
  end
`else
  assign timeout  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
  assign req0     = m0_cyc_i;
  assign req1     = m1_cyc_i;
`endif

endmodule

// File: tb/tb_wb_core_bus_arbiter.sv
// Directed bench for wb_core_bus_arbiter: round-robin instance plus a fixed-priority instance on shared inputs.
module tb_wb_core_bus_arbiter;
  localparam int AW = 32, DW = 32, SW = DW / 8;

  logic sys_clk = 1'b0, rst_n = 1'b0;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, core_ack;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdat, m1_wdat, core_rdat;

  logic [DW-1:0] m0_data, m1_data, c_data, f_m0_data, f_m1_data, f_c_data;
  logic m0_ack, m0_err, m1_ack, m1_err, c_cyc, c_stb, c_we;
  logic f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_c_cyc, f_c_stb, f_c_we;
  logic [SW-1:0] c_wstrb, f_c_wstrb;
  logic [AW-1:0] c_addr, f_c_addr;
  logic [1:0] grant, f_grant;

  int tests = 0, fails = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] q0[$], q1[$];
  logic [1:0]    gq[$];

  always #5 sys_clk = ~sys_clk;

  wb_core_bus_arbiter #(.PRIORITY_MODE(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_wstrb_i(m0_wstrb),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(m0_data), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_wstrb_i(m1_wstrb),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(m1_data), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .core_cyc_o(c_cyc), .core_stb_o(c_stb), .core_we_o(c_we), .core_wstrb_o(c_wstrb),
    .core_addr_o(c_addr), .core_data_o(c_data), .core_data_i(core_rdat), .core_ack_i(core_ack),
    .grant_o(grant));

  wb_core_bus_arbiter #(.PRIORITY_MODE(0), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut_fp (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_wstrb_i(m0_wstrb),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_data_o(f_m0_data), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_wstrb_i(m1_wstrb),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_data_o(f_m1_data), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
    .core_cyc_o(f_c_cyc), .core_stb_o(f_c_stb), .core_we_o(f_c_we), .core_wstrb_o(f_c_wstrb),
    .core_addr_o(f_c_addr), .core_data_o(f_c_data), .core_data_i(core_rdat), .core_ack_i(core_ack),
    .grant_o(f_grant));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(); @(posedge sys_clk); #1; endtask
  task automatic smp();  @(negedge sys_clk); endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, core_ack} = '0;
    m0_wstrb = '0; m1_wstrb = '0; m0_addr = '0; m1_addr = '0;
    m0_wdat = '0; m1_wdat = '0; core_rdat = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0; step(); step();
    rst_n = 1'b1; step();
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g);
    int n = 0;
    do begin smp(); n++; end while (grant !== g && n < 20);
    chk(tag, grant, g);
  endtask

  // Scoreboard: every ack to a master pops the read data expected for that master.
  always @(negedge sys_clk) if (mon_en) begin
    if (m0_ack) begin
      if (q0.size() == 0) chk("m0_ack_unexpected", m0_ack, 1'b0);
      else chk("m0_rdata", m0_data, q0.pop_front());
      chk("m0_ack_owner", grant, 2'b01);
    end
    if (m1_ack) begin
      if (q1.size() == 0) chk("m1_ack_unexpected", m1_ack, 1'b0);
      else chk("m1_rdata", m1_data, q1.pop_front());
      chk("m1_ack_owner", grant, 2'b10);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] e;
    clear_inputs();
    step(); step(); smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_core_cyc", c_cyc, 1'b0);
    chk("rst_core_stb", c_stb, 1'b0);
    chk("rst_core_addr", c_addr, 32'h0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_errs", {m0_err, m1_err}, 2'b00);
    step(); rst_n = 1'b1; step();
    mon_en = 1'b1;

    // m0 single read, slave acks two cycles after stb
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
    smp(); chk("t1_latency_cyc", c_cyc, 1'b0);
    step(); smp();
    chk("t1_grant", grant, 2'b01);
    chk("t1_core_cyc", c_cyc, 1'b1);
    chk("t1_core_addr", c_addr, 32'h10);
    step(); step();
    core_rdat = 32'hDEADBEEF; core_ack = 1; q0.push_back(32'hDEADBEEF);
    smp();
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m1_ack", m1_ack, 1'b0);
    step(); core_ack = 0; m0_cyc = 0; m0_stb = 0;
    smp(); chk("t1_release_cyc", c_cyc, 1'b0);
    step(); smp(); chk("t1_idle_grant", grant, 2'b00);

    // fixed priority tie: m1 write wins, m0 takes over with no dead cycle
    mon_en = 1'b0;
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h20;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h1000; m1_wdat = 32'h12345678; m1_wstrb = 4'hF;
    step(); smp();
    chk("t2_fp_grant", f_grant, 2'b10);
    chk("t2_fp_we", f_c_we, 1'b1);
    chk("t2_fp_addr", f_c_addr, 32'h1000);
    chk("t2_fp_wdata", f_c_data, 32'h12345678);
    chk("t2_fp_wstrb", f_c_wstrb, 4'hF);
    chk("t2_rr_grant", grant, 2'b01);
    step(); core_ack = 1;
    smp();
    chk("t2_fp_m1_ack", f_m1_ack, 1'b1);
    chk("t2_fp_m0_ack", f_m0_ack, 1'b0);
    step(); core_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    smp();
    chk("t2_fp_release_cyc", f_c_cyc, 1'b0);
    chk("t2_fp_hold_grant", f_grant, 2'b10);
    step(); smp();
    chk("t2_fp_handover", f_grant, 2'b01);
    chk("t2_fp_m0_addr", f_c_addr, 32'h20);

    // round robin: six back-to-back single beats alternate starting with m0
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) gq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 6; i++) begin
      e = gq.pop_front();
      wait_grant($sformatf("t3_rr_grant%0d", i), e);
      step();
      core_rdat = 32'hA000_0000 + 32'(i); core_ack = 1;
      if (e == 2'b01) q0.push_back(core_rdat); else q1.push_back(core_rdat);
      step(); core_ack = 0;
      if (e == 2'b01) {m0_cyc, m0_stb} = 2'b00; else {m1_cyc, m1_stb} = 2'b00;
      step();
      if (e == 2'b01) {m0_cyc, m0_stb} = 2'b11; else {m1_cyc, m1_stb} = 2'b11;
    end

    // m1 holds cyc through a 4-beat burst while m0 waits
    do_reset();
    m1_cyc = 1; m1_stb = 1; step();
    m0_cyc = 1; m0_stb = 1;
    wait_grant("t4_grant_m1", 2'b10);
    for (int b = 0; b < 4; b++) begin
      step(); core_rdat = 32'hB000_0000 + 32'(b); core_ack = 1; q1.push_back(core_rdat);
      smp();
      chk($sformatf("t4_hold%0d", b), grant, 2'b10);
      chk($sformatf("t4_m0_noack%0d", b), m0_ack, 1'b0);
    end
    step(); core_ack = 0; m1_cyc = 0; m1_stb = 0;
    smp(); chk("t4_release_hold", grant, 2'b10);
    step(); smp(); chk("t4_m0_granted", grant, 2'b01);
    step(); core_rdat = 32'hC0DE_0001; core_ack = 1; q0.push_back(core_rdat);
    step(); clear_inputs();

    // asynchronous reset while m0 owns the bus with stb pending
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h44;
    wait_grant("t5_grant_m0", 2'b01);
    step(); #1 rst_n = 1'b0; #1;
    chk("t5_async_grant", grant, 2'b00);
    chk("t5_async_cyc", c_cyc, 1'b0);
    chk("t5_async_addr", c_addr, 32'h0);
    core_ack = 1; #1;
    chk("t5_ack_in_reset", m0_ack, 1'b0);
    step(); rst_n = 1'b1; m0_cyc = 0; m0_stb = 0;
    smp();
    chk("t5_late_ack", {m0_ack, m1_ack}, 2'b00);
    chk("t5_idle_grant", grant, 2'b00);
    step(); core_ack = 0;

    // m1 stalls forever with m0 pending
    do_reset();
    m1_cyc = 1; m1_stb = 1; step();
    m0_cyc = 1; m0_stb = 1;
    smp(); chk("t6_grant_m1", grant, 2'b10);
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 2; k <= 7; k++) begin
      step(); smp(); chk($sformatf("t6_no_err%0d", k), m1_err, 1'b0);
    end
    step(); smp();
    chk("t6_m1_err", m1_err, 1'b1);
    chk("t6_m0_err", m0_err, 1'b0);
    step(); smp();
    chk("t6_drop_cyc", c_cyc, 1'b0);
    chk("t6_err_pulse", m1_err, 1'b0);
    chk("t6_idle", grant, 2'b00);
    step(); smp();
    chk("t6_m0_after_timeout", grant, 2'b01);
`else
    for (int k = 2; k <= 12; k++) begin
      step(); smp(); chk($sformatf("t6_no_err%0d", k), {m0_err, m1_err, grant}, 4'b0010);
    end
`endif
    step(); clear_inputs();
    step(); step(); smp();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_core_bus_arbiter.md
Name: wb_core_bus_arbiter

Overview:
- Shares the single Wishbone core bus (core_* toward Controller memory) between the core's instruction-fetch master (m0) and data master (m1).
- Used when ENABLE_SECOND_MEMORY is not defined.
- Sits between the processor and processorci_top's core_* port.
- Grants one master at a time, holds the grant for the whole cyc transaction, and routes ack/data back to the owning master only.

Parameters:
- PRIORITY_MODE, 1, 0 = fixed priority (m1 data wins ties); 1 = round-robin (loser of last arbitration wins the next tie).
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; wstrb width = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, stall limit used only with WB_ARB_TIMEOUT_EN; legal range 2..65535.

Ports:
- sys_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1  instruction master Wishbone controls
- m0_wstrb_i  in  DATA_WIDTH/8  byte strobes
- m0_addr_i  in  ADDR_WIDTH  address
- m0_data_i  in  DATA_WIDTH  write data
- m0_data_o  out  DATA_WIDTH  read data
- m0_ack_o  out  1  ack to m0
- m0_err_o  out  1  timeout error pulse to m0
- m1_*  same set and widths as m0_*  data master
- core_cyc_o, core_stb_o, core_we_o  out  1  shared bus controls
- core_wstrb_o  out  DATA_WIDTH/8  byte strobes
- core_addr_o  out  ADDR_WIDTH  address
- core_data_o  out  DATA_WIDTH  write data
- core_data_i  in  DATA_WIDTH  read data
- core_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner: bit0 = m0, bit1 = m1

Behaviour:
- One clock, sys_clk. Reset rst_n is asynchronous, active-low.
- State machine: IDLE, OWN_M0, OWN_M1. Register last_winner (reset 1, so m0 wins the first round-robin tie).
- Reset values:
  - state = IDLE, grant_o = 2'b00.
  - All core_* outputs 0; m*_ack_o = 0, m*_err_o = 0.
  - Timeout counter = 0.
- IDLE:
  - Only m0_cyc_i high -> OWN_M0. Only m1_cyc_i high -> OWN_M1.
  - Both high: PRIORITY_MODE=0 -> OWN_M1. PRIORITY_MODE=1 -> the master that is not last_winner.
  - Neither high -> stay IDLE.
  - last_winner updates on every grant.
- Grant is registered: core_cyc_o asserts the cycle after the master's cyc is first seen in IDLE (1-cycle arbitration latency).
- OWN_Mx:
  - core_cyc/stb/we/wstrb/addr/data = combinational copy of master x.
  - m_x_ack_o = core_ack_i; the other master's ack stays 0.
  - Both m*_data_o = core_data_i at all times; masters must qualify with ack.
- Release when the owner drops cyc:
  - In that cycle core_cyc_o follows the owner (already low).
  - Next state is chosen by the same IDLE arbitration rules, so a waiting master gets OWN_My on the next cycle (no dead cycle).
- No preemption: a master holding cyc across multiple stb/ack beats keeps the bus indefinitely, except on timeout.
- Ack arriving while no master is granted, or after the owner dropped cyc, is discarded.
- Reset asserted mid-transaction: everything returns to reset values immediately (asynchronous); no ack is delivered.
- The non-owner's stb/we are ignored; no buffering of its request.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each cycle in OWN_Mx with core_stb_o=1 and core_ack_i=0.
  - It clears on ack, on release, and on state change.
  - On reaching TIMEOUT_CYCLES-1: m_x_err_o pulses high for exactly 1 cycle, and the grant is forcibly dropped (core_cyc_o = 0 next cycle).
  - State goes to IDLE with last_winner = x. The timed-out master must drop cyc before it can be granted again.
- Undefined: no counter; m*_err_o tied 0; ports still present.

Test Plan:
- m0 only, read addr 0x00000010, slave acks 2 cycles after stb with 0xDEADBEEF -> core_cyc_o high 1 cycle after m0_cyc_i; m0_ack_o=1 with m0_data_o=0xDEADBEEF; m1_ack_o stays 0; grant_o=01.
- Simultaneous m0/m1 requests, PRIORITY_MODE=0 -> grant_o=10; m1 write 0x12345678 to 0x00001000 appears on core_*. After m1 drops cyc, grant_o=01 on the very next cycle.
- PRIORITY_MODE=1, both masters requesting continuously, 6 back-to-back single-beat transactions -> grants alternate m0, m1, m0, m1, m0, m1, starting with m0 after reset.
- m1 holds cyc for a 4-beat burst while m0 requests -> m0 receives no ack and grant_o stays 10 for all 4 beats; m0 is granted the cycle after m1's cyc falls.
- Reset pulsed low while OWN_M0 with stb pending -> all core_* and ack outputs 0 asynchronously; after reset, a late core_ack_i is not forwarded.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks m1 -> m1_err_o high for 1 cycle after 8 stalled cycles; core_cyc_o drops next cycle; pending m0 is granted afterwards.
